// File: rtl/temp_bcd_fmt_if.sv
// ============================================================================
// Module   : temp_bcd_fmt_if
// Brief    : Sample-in / formatted-code-out bundle for the temperature formatter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface temp_bcd_fmt_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] temp_in;
   logic              temp_valid;
   logic              busy;
   logic              done;
   logic [19:0]       hms_out;
   logic              sat;
   logic              alarm;

   modport master (
      output temp_in, temp_valid,
      input  busy, done, hms_out, sat, alarm
   );

   modport slave (
      input  temp_in, temp_valid,
      output busy, done, hms_out, sat, alarm
   );
endinterface

`default_nettype wire

// File: rtl/temp_bcd_fmt.sv
// ============================================================================
// Module   : temp_bcd_fmt
// Brief    : Signed fixed-point temperature to {sign,h,t,o,tenths} BCD code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module temp_bcd_fmt #(
   parameter int         DATA_W    = 16,
   parameter int         FRAC_BITS = 8,
   parameter logic [3:0] POS_CODE  = 4'd0,
   parameter logic [3:0] NEG_CODE  = 4'd10,
   parameter int         T_OS      = 80,
   parameter int         T_HYST    = 75
) (
   input  wire logic     sys_clk,
   input  wire logic     rst_n,
   temp_bcd_fmt_if.slave bus
);

   localparam int IW    = DATA_W - FRAC_BITS;
   localparam int FW    = (FRAC_BITS > 0) ? FRAC_BITS : 1;
   localparam int CNT_W = (IW > 1) ? $clog2(IW) : 1;
   localparam logic signed [DATA_W:0] OS_TH = (DATA_W+1)'(T_OS <<< FRAC_BITS);
   localparam logic signed [DATA_W:0] HY_TH = (DATA_W+1)'(T_HYST <<< FRAC_BITS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CONV = 3'd2,
      S_FRAC = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic              sign_q;
   logic [IW-1:0]     int_q;
   logic [FW-1:0]     frac_q;
   logic [11:0]       bcd_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              satf_q;
   logic [3:0]        tenths_q;
   logic [19:0]       hms_q;
   logic              sat_q;
   logic              alarm_q;
   logic              done_q;

   logic [DATA_W:0]   data_ext;
   logic [DATA_W:0]   mag;
   logic [IW-1:0]     int_part;
   logic [FW-1:0]     frac_part;
   logic [3:0]        tenths_calc;
   logic [11:0]       bcd_adj;
   logic              over_range;

   // One extra bit keeps the negation of the most negative input exact.
   assign data_ext   = {data_q[DATA_W-1], data_q};
   assign mag        = data_q[DATA_W-1] ? -data_ext : data_ext;
   assign int_part   = mag[DATA_W-1:FRAC_BITS];
   assign over_range = mag[DATA_W] | (32'(int_part) > 32'd999);

   generate
      if (FRAC_BITS > 0) begin : g_frac
         assign frac_part   = mag[FW-1:0];
         assign tenths_calc = 4'((({4'b0, frac_q}) * 10) >> FW);
      end else begin : g_nofrac
         assign frac_part   = 1'b0;
         assign tenths_calc = 4'd0;
      end
   endgenerate

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.temp_valid) state_d = S_LOAD;
         S_LOAD:  state_d = S_CONV;
         S_CONV:  if (cnt_q == '0) state_d = S_FRAC;
         S_FRAC:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         sign_q   <= 1'b0;
         int_q    <= '0;
         frac_q   <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         satf_q   <= 1'b0;
         tenths_q <= '0;
         hms_q    <= '0;
         sat_q    <= 1'b0;
         alarm_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.temp_valid) data_q <= bus.temp_in;
            end
            S_LOAD: begin
               sign_q <= data_q[DATA_W-1];
               int_q  <= int_part;
               frac_q <= frac_part;
               satf_q <= over_range;
               bcd_q  <= '0;
               cnt_q  <= CNT_W'(IW - 1);
            end
            S_CONV: begin
               bcd_q <= {bcd_adj[10:0], int_q[IW-1]};
               int_q <= int_q << 1;
               cnt_q <= cnt_q - 1'b1;
            end
            S_FRAC: begin
               tenths_q <= tenths_calc;
            end
            S_DONE: begin
               hms_q[19:16] <= sign_q ? NEG_CODE : POS_CODE;
               hms_q[15:0]  <= satf_q ? 16'h9999 : {bcd_q, tenths_q};
               sat_q        <= satf_q;
               done_q       <= 1'b1;
               // Hysteresis band between the thresholds leaves the flag unchanged.
               if ($signed(data_ext) >= OS_TH) begin
                  alarm_q <= 1'b1;
               end else if ($signed(data_ext) < HY_TH) begin
                  alarm_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = done_q;
   assign bus.hms_out = hms_q;
   assign bus.sat     = sat_q;
   assign bus.alarm   = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_temp_bcd_fmt.sv
// ============================================================================
// Module   : tb_temp_bcd_fmt
// Brief    : Self-checking bench for temp_bcd_fmt (Q8.8 and Q12.0 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_temp_bcd_fmt;

   logic sys_clk = 1'b0;
   logic rst_n;
   always #5 sys_clk = ~sys_clk;

   temp_bcd_fmt_if #(.DATA_W(16)) bus0 ();
   temp_bcd_fmt_if #(.DATA_W(12)) bus1 ();

   temp_bcd_fmt u_dut0 (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus0)
   );

   temp_bcd_fmt #(.DATA_W(12), .FRAC_BITS(0)) u_dut1 (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus1)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit m_alarm [2];

   typedef struct {
      logic [15:0] t;
      logic [19:0] hms;
      logic        sat;
      logic        alarm;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain decimal arithmetic on the signed value.
   function automatic logic [20:0] ref_fmt(input longint v, input int fb);
      longint mag, ip, fp, tn;
      logic [3:0] sc;
      mag = (v < 0) ? -v : v;
      ip  = mag >> fb;
      fp  = mag - (ip << fb);
      tn  = (fp * 10) >> fb;
      sc  = (v < 0) ? 4'd10 : 4'd0;
      if (ip > 999) return {1'b1, sc, 16'h9999};
      return {1'b0, sc, 4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10), 4'(tn)};
   endfunction

   function automatic void upd_alarm(input int idx, input longint v, input int fb);
      if (v >= (longint'(80) << fb))      m_alarm[idx] = 1'b1;
      else if (v < (longint'(75) << fb))  m_alarm[idx] = 1'b0;
   endfunction

   task automatic run(input bit w12, input logic [15:0] v,
                      output logic [19:0] hms, output logic s, output logic a);
      int lat;
      int fb;
      longint sv;
      logic [20:0] e;
      @(negedge sys_clk);
      if (w12) begin bus1.temp_in = v[11:0]; bus1.temp_valid = 1'b1; end
      else     begin bus0.temp_in = v;       bus0.temp_valid = 1'b1; end
      @(posedge sys_clk);
      #1;
      bus0.temp_valid = 1'b0;
      bus1.temp_valid = 1'b0;
      chk("busy_after_accept", w12 ? bus1.busy : bus0.busy, 1);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge sys_clk);
         #1;
         if (w12 ? bus1.done : bus0.done) begin lat = k; break; end
      end
      hms = w12 ? bus1.hms_out : bus0.hms_out;
      s   = w12 ? bus1.sat     : bus0.sat;
      a   = w12 ? bus1.alarm   : bus0.alarm;
      fb  = w12 ? 0 : 8;
      sv  = w12 ? longint'($signed(v[11:0])) : longint'($signed(v));
      e   = ref_fmt(sv, fb);
      upd_alarm(int'(w12), sv, fb);
      chk("latency", lat, w12 ? 15 : 11);
      chk("busy_at_done", w12 ? bus1.busy : bus0.busy, 0);
      chk("model_hms", hms, e[19:0]);
      chk("model_sat", s, e[20]);
      chk("model_alarm", a, m_alarm[int'(w12)]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [10];
      logic [19:0] h;
      logic        s, a;
      logic [15:0] v;
      int          ndone, first;

      tbl[0] = '{16'h1980, 20'h00255, 1'b0, 1'b0};
      tbl[1] = '{16'hE700, 20'hA0250, 1'b0, 1'b0};
      tbl[2] = '{16'hFF80, 20'hA0005, 1'b0, 1'b0};
      tbl[3] = '{16'h7F80, 20'h01275, 1'b0, 1'b1};
      tbl[4] = '{16'h8000, 20'hA1280, 1'b0, 1'b0};
      tbl[5] = '{16'h5000, 20'h00800, 1'b0, 1'b1};
      tbl[6] = '{16'h4C00, 20'h00760, 1'b0, 1'b1};
      tbl[7] = '{16'h4B00, 20'h00750, 1'b0, 1'b1};
      tbl[8] = '{16'h4A80, 20'h00745, 1'b0, 1'b0};
      tbl[9] = '{16'h4F80, 20'h00795, 1'b0, 1'b0};

      rst_n = 1'b0;
      bus0.temp_in = '0; bus0.temp_valid = 1'b0;
      bus1.temp_in = '0; bus1.temp_valid = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_busy0", bus0.busy, 0);   chk("rst_done0", bus0.done, 0);
      chk("rst_hms0", bus0.hms_out, 0); chk("rst_sat0", bus0.sat, 0);
      chk("rst_alarm0", bus0.alarm, 0);
      chk("rst_busy1", bus1.busy, 0);   chk("rst_hms1", bus1.hms_out, 0);
      @(negedge sys_clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run(1'b0, tbl[i].t, h, s, a);
         chk("tbl_hms", h, tbl[i].hms);
         chk("tbl_sat", s, tbl[i].sat);
         chk("tbl_alarm", a, tbl[i].alarm);
      end

      run(1'b1, 16'h07FF, h, s, a);
      chk("w12_sat_hms", h, 20'h09999);
      chk("w12_sat_flag", s, 1);
      run(1'b1, 16'h03E7, h, s, a);
      chk("w12_999_hms", h, 20'h09990);
      chk("w12_999_sat", s, 0);

      for (int i = 0; i < 30; i++) begin
         v = 16'($urandom);
         if (i % 3 == 0) v = 16'h4A00 + 16'($urandom_range(0, 16'h0700));
         run(1'b0, v, h, s, a);
      end
      for (int i = 0; i < 10; i++) begin
         v = 16'($urandom_range(0, 4095));
         run(1'b1, v, h, s, a);
      end

      // Second strobe while converting must be dropped.
      @(negedge sys_clk);
      bus0.temp_in = 16'h1980; bus0.temp_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      bus0.temp_valid = 1'b0;
      ndone = 0; first = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge sys_clk);
         if (k == 3) bus0.temp_in = 16'h0A00;
         bus0.temp_valid = (k == 3);
         @(posedge sys_clk);
         #1;
         if (bus0.done) begin
            ndone++;
            if (first == 0) first = k;
         end
      end
      bus0.temp_valid = 1'b0;
      upd_alarm(0, 25 * 256 + 128, 8);
      chk("dbl_ndone", ndone, 1);
      chk("dbl_latency", first, 11);
      chk("dbl_hms", bus0.hms_out, 20'h00255);

      // Reset in the middle of the bit-serial phase.
      @(negedge sys_clk);
      bus0.temp_in = 16'h7F80; bus0.temp_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      bus0.temp_valid = 1'b0;
      repeat (3) @(posedge sys_clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", bus0.busy, 0);   chk("mid_done", bus0.done, 0);
      chk("mid_hms", bus0.hms_out, 0); chk("mid_sat", bus0.sat, 0);
      chk("mid_alarm", bus0.alarm, 0);
      @(negedge sys_clk);
      rst_n = 1'b1;
      m_alarm[0] = 1'b0;
      m_alarm[1] = 1'b0;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge sys_clk);
         #1;
         if (bus0.done) ndone++;
      end
      chk("mid_no_done", ndone, 0);
      run(1'b0, 16'hE700, h, s, a);
      chk("post_rst_hms", h, 20'hA0250);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
